// File: rtl/vim828_pkg.sv
// Shared definitions for the VIM-828 LCD glass driver.
// Holds the glass pin index macros, pin/segment counts, and the DAC level codes
// with the helpers that turn (selected/on, polarity) into a level.
`ifndef VIM828_PIN_MACROS
`define VIM828_PIN_MACROS
`define COM0 0
`define COM1 1
`define COM2 2
`define COM3 3
`define SEG(n) (4 + (n))
`endif

package vim828_pkg;

    localparam int unsigned NUM_COMS   = 4;
    localparam int unsigned NUM_SEGS   = 30;
    localparam int unsigned NUM_PINS   = 34;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_SEGS = 14;
    localparam int unsigned DIGIT_BITS = 15;
    localparam int unsigned SEG_BITS   = 120;
    localparam int unsigned LVL_W      = 2;
    localparam int unsigned STATE_W    = 3;

    // External resistor-DAC level codes.
    typedef enum logic [1:0] {
        LVL_GND = 2'd0,
        LVL_1_3 = 2'd1,
        LVL_2_3 = 2'd2,
        LVL_VDD = 2'd3
    } lvl_e;

    // Pin p occupies bits [2p+1:2p].
    typedef logic [NUM_PINS-1:0][LVL_W-1:0] pin_vec_t;

    // COM drive: the selected COM swings to a rail, the others sit at the near bias level.
    function automatic lvl_e com_level(input logic sel, input logic inv);
        if (sel) return inv ? LVL_GND : LVL_VDD;
        return inv ? LVL_2_3 : LVL_1_3;
    endfunction

    // SEG drive: "on" sits at the rail opposite the selected COM, "off" at the far bias level.
    function automatic lvl_e seg_level(input logic on, input logic inv);
        if (on) return inv ? LVL_VDD : LVL_GND;
        return inv ? LVL_1_3 : LVL_2_3;
    endfunction

endpackage

// File: rtl/vim828_tick.sv
// Prescaler for the COM phase stepping.
// Ports: Clock/Reset (async active-low); change_state_c is high for one cycle
// while the counter sits at TICKS-1, i.e. once every TICKS cycles.
module vim828_tick #(
    parameter int unsigned TICKS = 2
) (
    input  logic Clock,
    input  logic Reset,
    output logic change_state_c
);

    localparam int unsigned CNT_W = $clog2(TICKS);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign change_state_c = (cnt_q == CNT_W'(TICKS - 1));

    // Free-running 0..TICKS-1 counter.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (change_state_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vim828.sv
// VIM-828 LCD glass driver: 4 COM + 30 SEG pins, 1/4 duty, 1/3 bias, DC-free.
// Ports: Clock, Reset (async active-low), Segments{7..0}_i (A..N bitmap per digit),
// DecimalPoints_i (DP per digit), Pin_o (2-bit DAC level code per glass pin,
// pins 0..3 = COM0..3, pins 4..33 = SEG0..29).
module vim828
    import vim828_pkg::*;
#(
    parameter int unsigned CLOCK_HZ      = 10_000_000,
    parameter int unsigned CHANGE_COM_US = 1000
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [DIGIT_SEGS-1:0]    Segments7_i,
    input  logic [DIGIT_SEGS-1:0]    Segments6_i,
    input  logic [DIGIT_SEGS-1:0]    Segments5_i,
    input  logic [DIGIT_SEGS-1:0]    Segments4_i,
    input  logic [DIGIT_SEGS-1:0]    Segments3_i,
    input  logic [DIGIT_SEGS-1:0]    Segments2_i,
    input  logic [DIGIT_SEGS-1:0]    Segments1_i,
    input  logic [DIGIT_SEGS-1:0]    Segments0_i,
    input  logic [NUM_DIGITS-1:0]    DecimalPoints_i,
    output logic [LVL_W*NUM_PINS-1:0] Pin_o
);

    // 64-bit product: the default clock times period overflows 32 bits.
    localparam longint unsigned TICKS_L =
        (64'(CLOCK_HZ) * 64'(CHANGE_COM_US)) / 64'd1_000_000;
    localparam int unsigned TICKS = 32'(TICKS_L);

    logic [DIGIT_SEGS-1:0] seg_arr [NUM_DIGITS];
    logic [SEG_BITS-1:0]   seg_flat;
    logic                  change_state_c;
    logic [STATE_W-1:0]    state_q;
    logic [STATE_W-1:0]    state_d;
    logic [1:0]            com_sel;
    logic                  inv;
    pin_vec_t              pin_q;
    pin_vec_t              pin_d;

    assign seg_arr[0] = Segments0_i;
    assign seg_arr[1] = Segments1_i;
    assign seg_arr[2] = Segments2_i;
    assign seg_arr[3] = Segments3_i;
    assign seg_arr[4] = Segments4_i;
    assign seg_arr[5] = Segments5_i;
    assign seg_arr[6] = Segments6_i;
    assign seg_arr[7] = Segments7_i;

    // Flatten to 15 bits per digit: A..N then DP.
    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        assign seg_flat[DIGIT_BITS*d +: DIGIT_SEGS]  = seg_arr[d];
        assign seg_flat[DIGIT_BITS*d + DIGIT_SEGS]   = DecimalPoints_i[d];
    end

    vim828_tick #(
        .TICKS (TICKS)
    ) u_tick (
        .Clock          (Clock),
        .Reset          (Reset),
        .change_state_c (change_state_c)
    );

    assign state_d = change_state_c ? state_q + STATE_W'(1) : state_q;
    assign com_sel = state_q[1:0];
    assign inv     = state_q[2];

    for (genvar c = 0; c < NUM_COMS; c++) begin : g_com
        assign pin_d[c] = com_level(com_sel == 2'(c), inv);
    end

    // SEG pin s carries flat bits 4s..4s+3, one per COM; pick the active COM's bit.
    for (genvar s = 0; s < NUM_SEGS; s++) begin : g_seg
        logic [NUM_COMS-1:0] grp;
        assign grp             = seg_flat[NUM_COMS*s +: NUM_COMS];
        assign pin_d[`SEG(s)]  = seg_level(grp[com_sel], inv);
    end

    // Phase counter and per-pin level registers; reset parks every pin at GND.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= '0;
            pin_q   <= '0;
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
        end
    end

    assign Pin_o = pin_q;

endmodule

// File: tb/tb_vim828.sv
module tb_vim828;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned COM_US = 50;
    localparam int unsigned TICKS  = 50;

    // {C3,C2,C1,C0} per state
    localparam logic [7:0] COM_TAB [8] = '{
        8'b01010111, 8'b01011101, 8'b01110101, 8'b11010101,
        8'b10101000, 8'b10100010, 8'b10001010, 8'b00101010
    };
    // SEG28 / SEG18 level per state with digit7 J and DP4 lit
    localparam logic [1:0] J_TAB [8] = '{
        2'd2, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd1
    };

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [13:0] seg [8];
    logic [7:0]  dp;
    logic [67:0] Pin_o;

    int          checks = 0;
    int          errors = 0;
    int unsigned edges  = 0;
    logic [67:0] exp_pin = '0;

    always #5 Clock = ~Clock;

    vim828 #(
        .CLOCK_HZ      (CLK_HZ),
        .CHANGE_COM_US (COM_US)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Segments7_i     (seg[7]),
        .Segments6_i     (seg[6]),
        .Segments5_i     (seg[5]),
        .Segments4_i     (seg[4]),
        .Segments3_i     (seg[3]),
        .Segments2_i     (seg[2]),
        .Segments1_i     (seg[1]),
        .Segments0_i     (seg[0]),
        .DecimalPoints_i (dp),
        .Pin_o           (Pin_o)
    );

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: glass level for every pin given a state number and the current inputs.
    function automatic logic [67:0] model(input int unsigned st);
        logic [119:0] flat;
        logic [67:0]  r;
        int unsigned  c;
        bit           neg;
        int unsigned  lvl;
        c   = st % 4;
        neg = (st >= 4);
        for (int d = 0; d < 8; d++) begin
            for (int b = 0; b < 14; b++) flat[15*d + b] = seg[d][b];
            flat[15*d + 14] = dp[d];
        end
        for (int p = 0; p < 4; p++) begin
            if (p == int'(c)) lvl = neg ? 0 : 3;
            else              lvl = neg ? 2 : 1;
            r[2*p +: 2] = 2'(lvl);
        end
        for (int j = 0; j < 30; j++) begin
            if (flat[4*j + int'(c)]) lvl = neg ? 3 : 0;
            else                     lvl = neg ? 1 : 2;
            r[2*(4+j) +: 2] = 2'(lvl);
        end
        return r;
    endfunction

    // State shown on Pin_o after the latest edge.
    function automatic int unsigned shown();
        return ((edges - 1) / TICKS) % 8;
    endfunction

    function automatic bool_mid();
        return 1'b0;
    endfunction

    task automatic set_all(input logic [13:0] s, input logic [7:0] p);
        for (int d = 0; d < 8; d++) seg[d] = s;
        dp = p;
    endtask

    // One clock: optional random inputs, predict at the edge, compare at the falling edge.
    task automatic step(input bit rnd);
        if (rnd) begin
            for (int d = 0; d < 8; d++) seg[d] = 14'($urandom);
            dp = 8'($urandom);
        end
        @(posedge Clock);
        if (!Reset) begin
            exp_pin = '0;
            edges   = 0;
        end else begin
            exp_pin = model((edges / TICKS) % 8);
            edges++;
        end
        @(negedge Clock);
        check("pin", Pin_o, exp_pin);
    endtask

    task automatic run_com(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0);
            if ((edges - 1) % TICKS == 25) check("com", 68'(Pin_o[7:0]), 68'(COM_TAB[shown()]));
        end
    endtask

    initial begin
        bit found;
        set_all('0, '0);

        // Held in reset
        for (int i = 0; i < 4; i++) step(1'b0);
        check("rst_hold", Pin_o, '0);
        Reset = 1'b1;

        // First edge after release: state 0 pattern
        step(1'b0);
        check("first_com", 68'(Pin_o[7:0]), 68'(8'b01010111));
        check("first_seg", 68'(Pin_o[67:8]), 68'({30{2'd2}}));

        // Free run, blank display, full COM cycle and wrap
        run_com(9 * TICKS);

        // Digit7 J and DP4
        seg[7] = 14'h0200;
        dp     = 8'h10;
        for (int i = 0; i < 8 * TICKS; i++) begin
            step(1'b0);
            if ((edges - 1) % TICKS == 25) begin
                check("seg28", 68'(Pin_o[65:64]), 68'(J_TAB[shown()]));
                check("seg18", 68'(Pin_o[45:44]), 68'(J_TAB[shown()]));
            end
        end

        // All on
        set_all('1, '1);
        for (int i = 0; i < 8 * TICKS; i++) begin
            step(1'b0);
            if ((edges - 1) % TICKS == 25)
                check("all_on", 68'(Pin_o[67:8]), 68'({30{shown() < 4 ? 2'd0 : 2'd3}}));
        end

        // All off
        set_all('0, '0);
        for (int i = 0; i < 8 * TICKS; i++) begin
            step(1'b0);
            if ((edges - 1) % TICKS == 25)
                check("all_off", 68'(Pin_o[67:8]), 68'({30{shown() < 4 ? 2'd2 : 2'd1}}));
        end

        // Mid-state toggle of digit0 A while COM0 is active
        found = 1'b0;
        for (int i = 0; i < 16 * TICKS && !found; i++) begin
            step(1'b0);
            if (shown() == 0 && (edges - 1) % TICKS == 10) found = 1'b1;
        end
        check("find_s0", 68'(found), 68'(1));
        seg[0][0] = 1'b1;
        step(1'b0);
        check("toggle_on", 68'(Pin_o[9:8]), 68'(2'd0));
        seg[0][0] = 1'b0;
        step(1'b0);
        check("toggle_off", 68'(Pin_o[9:8]), 68'(2'd2));

        // Random inputs every cycle
        for (int i = 0; i < 10 * TICKS; i++) step(1'b1);

        // Async reset mid state 5
        found = 1'b0;
        for (int i = 0; i < 16 * TICKS && !found; i++) begin
            step(1'b0);
            if (shown() == 5 && (edges - 1) % TICKS == 20) found = 1'b1;
        end
        check("find_s5", 68'(found), 68'(1));
        #2 Reset = 1'b0;
        #1 check("async_rst", Pin_o, '0);
        for (int i = 0; i < 3; i++) step(1'b0);
        Reset = 1'b1;
        step(1'b0);
        check("restart_com", 68'(Pin_o[7:0]), 68'(COM_TAB[0]));
        run_com(TICKS - 1);
        check("full_period", 68'(Pin_o[7:0]), 68'(COM_TAB[0]));
        step(1'b0);
        check("next_state", 68'(Pin_o[7:0]), 68'(COM_TAB[1]));
        run_com(8 * TICKS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vim828.md
Name: vim828

Overview:
- Drives the VIM-828 8-digit, 14-segment + decimal point LCD glass: 4 COM lines plus 30 segment lines, 1/4 duty, 1/3 bias.
- Each glass pin gets a 2-bit level code for an external resistor DAC (0, 1/3, 2/3, VDD).
- The waveform is DC-free: an 8-state cycle covering 4 COM phases, each in normal then inverted polarity.
- Sits between the display-formatting logic (segment bitmaps) and the FPGA pins.

Parameters:
- CLOCK_HZ, 10_000_000, system clock frequency in Hz.
- CHANGE_COM_US, 1000, duration of one state in microseconds. TICKS = CLOCK_HZ*CHANGE_COM_US/1_000_000, which must be ≥ 2.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Segments7_i .. Segments0_i  in  14 each  digit d segment bitmap: bit0=A … bit13=N (order A B C D E F G H I J K L M N); 1 = segment on.
- DecimalPoints_i  in  8  bit d = decimal point of digit d on.
- Pin_o  out  68  two bits per glass pin. Level code of pin p = Pin_o[2p+1:2p]: 0=GND, 1=1/3, 2=2/3, 3=VDD. Pins 0..3 = COM0..COM3, pins 4..33 = SEG0..SEG29.

Behaviour:
- Flat segment vector S[119:0]: S[15d+b] = Segments{d}_i[b] for b<14, and S[15d+14] = DecimalPoints_i[d].
- Index i maps to glass pin 4+(i/4) on COM (i%4).
- Tick counter counts 0..TICKS-1. At count TICKS-1:
  - counter wraps to 0;
  - internal ChangeState pulses high for exactly one cycle;
  - State (3 bits) increments, wrapping 7→0.
- Otherwise ChangeState = 0.
- Active COM c = State[1:0]; polarity inv = State[2].
- Per-pin level register PinVoltage[p] (2 bits), recomputed every cycle from the current State and the current inputs:
  - State 0-3 (inv=0): active COM=3, other COMs=1; SEG on=0, off=2.
  - State 4-7 (inv=1): active COM=0, other COMs=2; SEG on=3, off=1.
  - Resulting voltages: selected-on = ±3 levels, selected-off = ±1, non-selected = ±1. Average DC over 8 states = 0.
- Pin_o is the direct concatenation of PinVoltage; there is no further logic.
- Latency: an input change appears on Pin_o one clock later. Inputs are sampled continuously, not only at state boundaries.
- Reset asserted (Reset=0), asynchronously:
  - counter=0, State=0, ChangeState=0;
  - all PinVoltage = 0, so Pin_o = 0 and no DC on the glass.
- First clock after release: Pin_o shows the State 0 pattern. First ChangeState occurs TICKS cycles after release.
- Reset mid-cycle returns immediately to the reset values. There is no partial-state carryover.

Decomposition:
- Shared package/header vim828_defs holds:
  - pin index macros `COM0..`COM3 (=0..3), `SEG(n) (=4+n);
  - NUM_PINS=34;
  - level codes LVL_GND/LVL_1_3/LVL_2_3/LVL_VDD.
- One natural sub-module, vim828_tick: parameterised prescaler producing the ChangeState strobe.
- Segment mapping and level generation stay in vim828 as generate loops.

Test Plan:
- Bench setup: CLOCK_HZ=1_000_000, CHANGE_COM_US=50 (TICKS=50).
- Reset held low → Pin_o=0 throughout. Release → next cycle COM0=3, COM1/2/3=1, all SEGs=2.
- Free run, all segment inputs 0 → ChangeState pulses every 50 cycles. COM levels (C0..C3) per state:
  - state0: 3111
  - state1: 1311
  - state2: 1131
  - state3: 1113
  - state4: 0222
  - state5: 2022
  - state6: 2202
  - state7: 2220
  - then back to state0.
- Segments7_i=14'b0000_10000_00000 (digit 7, J) and DecimalPoints_i=8'b00010000 (DP4):
  - SEG28 (pin 32) = 0 in state2 and 3 in state6; otherwise 2 (states 0-3) / 1 (states 4-7);
  - SEG18 (pin 22) behaves the same.
- All inputs all-ones → every SEG pin = 0 in states 0-3 and 3 in states 4-7. All inputs zero → SEG 2/1.
- Toggle Segments0_i[0] mid-state → SEG0 level changes on the next clock edge, without waiting for ChangeState.
- Assert reset mid-state 5 → Pin_o=0 asynchronously (before the next clock edge). After release, the sequence restarts at state 0 with a full 50-cycle period.
